// File: rtl/pcf8591_pkg.sv
// Shared types and helpers for the PCF8591 scan sequencer.
// Channel selection helpers scan a 4-bit enable mask in ascending AIN order.
package pcf8591_pkg;

    localparam int         NUM_CH        = 4;
    localparam logic [7:0] CTRL_BASE_DEF = 8'h40;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GAP,
        ST_WR_EXEC,
        ST_WR_WAIT,
        ST_RD0_EXEC,
        ST_RD0_WAIT,
        ST_RD1_EXEC,
        ST_RD1_WAIT,
        ST_STORE
    } state_t;

    // Returns {found, ch}: lowest set bit of mask strictly above cur.
    function automatic logic [2:0] next_ch(input logic [3:0] mask, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'b000;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] first_ch(input logic [3:0] mask);
        logic [1:0] r;
        r = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pcf8591_wait_cnt.sv
// Loadable down-counter used for both inter-transaction gaps and done timeouts.
// Load wins over enable; the count saturates at zero.
module pcf8591_wait_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pcf8591_scan_ctrl.sv
// Round-robin PCF8591 ADC scanner driving i2c_dri: control write, dummy read, kept read per channel.
// Optional macro PCF8591_AVG_EN: four kept reads per channel, stores their truncated mean.
module pcf8591_scan_ctrl
    import pcf8591_pkg::*;
#(
    parameter int         GAP_CYC     = 250,
    parameter int         TIMEOUT_CYC = 4000,
    parameter logic [7:0] CTRL_BASE   = CTRL_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic [3:0]  ch_mask,
    input  logic [7:0]  dac_val,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic [7:0]  i2c_data_r,
    input  logic        i2c_done,
    output logic [31:0] ch_data,
    output logic [3:0]  ch_valid,
    output logic        scan_done,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [15:0] GAP_LD = 16'(GAP_CYC - 1);
    // Wait-state load makes timeout_err visible exactly TIMEOUT_CYC cycles after the exec cycle.
    localparam logic [15:0] TO_LD  = 16'(TIMEOUT_CYC - 2);

    state_t       state_q, state_d, pend_q, pend_d;
    logic [1:0]   cur_q, cur_d;
    logic [3:0]   mask_q, mask_d;
    logic [7:0]   dac_q, dac_d, ctrl_q, ctrl_d;
    logic         skip_q, skip_d, to_err_q, to_err_d, scan_done_q, scan_done_d;
    logic [31:0]  ch_data_q, ch_data_d;
    logic [3:0]   ch_valid_q, ch_valid_d;
    logic [2:0]   nxt;
    logic         cnt_load, cnt_en, cnt_zero;
    logic [15:0]  cnt_val;
    logic [7:0]   store_val;

`ifdef PCF8591_AVG_EN
    logic [9:0]   acc_q, acc_d;
    logic [1:0]   samp_q, samp_d;
    assign store_val = acc_q[9:2];
`else
    logic [7:0]   res_q, res_d;
    assign store_val = res_q;
`endif

    pcf8591_wait_cnt #(.W(16)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cur_d       = cur_q;
        mask_d      = mask_q;
        dac_d       = dac_q;
        ctrl_d      = ctrl_q;
        skip_d      = skip_q;
        to_err_d    = to_err_q;
        ch_data_d   = ch_data_q;
        ch_valid_d  = 4'b0000;
        scan_done_d = 1'b0;
        cnt_load    = 1'b0;
        cnt_val     = GAP_LD;
        cnt_en      = 1'b0;
        nxt         = next_ch(mask_q, cur_q);
`ifdef PCF8591_AVG_EN
        acc_d       = acc_q;
        samp_d      = samp_q;
`else
        res_d       = res_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (scan_en && (ch_mask != 4'b0000)) begin
                    mask_d  = ch_mask;
                    cur_d   = first_ch(ch_mask);
                    ctrl_d  = CTRL_BASE | {6'd0, first_ch(ch_mask)};
                    dac_d   = dac_val;
                    state_d = ST_WR_EXEC;
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_d = pend_q;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_WR_EXEC, ST_RD0_EXEC, ST_RD1_EXEC: begin
                cnt_load = 1'b1;
                cnt_val  = TO_LD;
                if (state_q == ST_WR_EXEC) begin
                    skip_d  = 1'b0;
                    state_d = ST_WR_WAIT;
`ifdef PCF8591_AVG_EN
                    acc_d   = '0;
                    samp_d  = '0;
`endif
                end else begin
                    state_d = (state_q == ST_RD0_EXEC) ? ST_RD0_WAIT : ST_RD1_WAIT;
                end
            end
            ST_WR_WAIT, ST_RD0_WAIT, ST_RD1_WAIT: begin
                cnt_en = 1'b1;
                if (i2c_done) begin
                    if (state_q == ST_RD1_WAIT) begin
`ifdef PCF8591_AVG_EN
                        acc_d = acc_q + {2'b00, i2c_data_r};
                        if (samp_q == 2'd3) begin
                            state_d = ST_STORE;
                        end else begin
                            samp_d   = samp_q + 2'd1;
                            pend_d   = ST_RD1_EXEC;
                            state_d  = ST_GAP;
                            cnt_load = 1'b1;
                        end
`else
                        res_d   = i2c_data_r;
                        state_d = ST_STORE;
`endif
                    end else begin
                        pend_d   = (state_q == ST_WR_WAIT) ? ST_RD0_EXEC : ST_RD1_EXEC;
                        state_d  = ST_GAP;
                        cnt_load = 1'b1;
                    end
                end else if (cnt_zero) begin
                    // Abandon the channel; STORE still runs to advance the pass.
                    to_err_d = 1'b1;
                    skip_d   = 1'b1;
                    state_d  = ST_STORE;
                end
            end
            ST_STORE: begin
                if (!skip_q) begin
                    ch_data_d[{cur_q, 3'b000} +: 8] = store_val;
                    ch_valid_d[cur_q]               = 1'b1;
                end
                state_d = ST_IDLE;
                if (nxt[2]) begin
                    if (scan_en) begin
                        cur_d    = nxt[1:0];
                        ctrl_d   = CTRL_BASE | {6'd0, nxt[1:0]};
                        pend_d   = ST_WR_EXEC;
                        state_d  = ST_GAP;
                        cnt_load = 1'b1;
                    end
                end else begin
                    scan_done_d = 1'b1;
                    if (scan_en && (ch_mask != 4'b0000)) begin
                        mask_d   = ch_mask;
                        cur_d    = first_ch(ch_mask);
                        ctrl_d   = CTRL_BASE | {6'd0, first_ch(ch_mask)};
                        dac_d    = dac_val;
                        pend_d   = ST_WR_EXEC;
                        state_d  = ST_GAP;
                        cnt_load = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= ST_IDLE;
            cur_q       <= '0;
            mask_q      <= '0;
            dac_q       <= '0;
            ctrl_q      <= '0;
            skip_q      <= 1'b0;
            to_err_q    <= 1'b0;
            ch_data_q   <= '0;
            ch_valid_q  <= '0;
            scan_done_q <= 1'b0;
`ifdef PCF8591_AVG_EN
            acc_q       <= '0;
            samp_q      <= '0;
`else
            res_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cur_q       <= cur_d;
            mask_q      <= mask_d;
            dac_q       <= dac_d;
            ctrl_q      <= ctrl_d;
            skip_q      <= skip_d;
            to_err_q    <= to_err_d;
            ch_data_q   <= ch_data_d;
            ch_valid_q  <= ch_valid_d;
            scan_done_q <= scan_done_d;
`ifdef PCF8591_AVG_EN
            acc_q       <= acc_d;
            samp_q      <= samp_d;
`else
            res_q       <= res_d;
`endif
        end
    end

    // Decoded from state so an async reset drops exec and direction immediately.
    assign i2c_exec    = (state_q == ST_WR_EXEC) || (state_q == ST_RD0_EXEC) || (state_q == ST_RD1_EXEC);
    assign i2c_rh_wl   = (state_q == ST_RD0_EXEC) || (state_q == ST_RD0_WAIT) ||
                         (state_q == ST_RD1_EXEC) || (state_q == ST_RD1_WAIT);
    assign i2c_addr    = {8'h00, ctrl_q};
    assign i2c_data_w  = dac_q;
    assign ch_data     = ch_data_q;
    assign ch_valid    = ch_valid_q;
    assign scan_done   = scan_done_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = to_err_q;

endmodule

// File: tb/tb_pcf8591_scan_ctrl.sv
// Bench for pcf8591_scan_ctrl: randomized i2c_dri bus model plus a transaction-list / register-file reference.
module tb_pcf8591_scan_ctrl;

    localparam int GAP = 5;
    localparam int TO  = 40;
`ifdef PCF8591_AVG_EN
    localparam int TPC   = 6;
    localparam int NKEEP = 4;
`else
    localparam int TPC   = 3;
    localparam int NKEEP = 1;
`endif

    logic        clk, rst, scan_en, i2c_exec, i2c_rh_wl, i2c_done, scan_done, busy, timeout_err;
    logic [3:0]  ch_mask, ch_valid;
    logic [7:0]  dac_val, i2c_data_w, i2c_data_r;
    logic [15:0] i2c_addr;
    logic [31:0] ch_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  samp_tab [4][4];
    logic [7:0]  exp_data [4];
    int          withhold_ch = -1;
    int          wh_exec_cyc = -1;
    bit          tr_rw[$];
    logic [15:0] tr_addr[$];
    logic [7:0]  tr_dw[$];
    bit          exp_rw[$];
    logic [15:0] exp_addr[$];
    logic [7:0]  exp_dw[$];
    int          proto_err = 0, stab_err = 0, spacing_err = 0, last_exec_cyc = -100000;
    int          vld_cnt [4];
    int          sd_cnt = 0, vld_cyc = -1, busy_fall_cyc = -1, to_rise_cyc = -1;
    logic        to_prev = 1'b0, busy_prev = 1'b0;

    pcf8591_scan_ctrl #(.GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .ch_mask(ch_mask), .dac_val(dac_val),
        .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w),
        .i2c_data_r(i2c_data_r), .i2c_done(i2c_done), .ch_data(ch_data), .ch_valid(ch_valid),
        .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // i2c_dri model: one outstanding transaction, random latency, optional withheld done.
    initial begin
        int unsigned lat;
        logic [7:0]  resp;
        bit          hold, aborted, rec_rw;
        logic [15:0] rec_addr;
        logic [7:0]  rec_dw;
        int          rd_idx;
        i2c_done = 1'b0;
        i2c_data_r = 8'h00;
        rd_idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) last_exec_cyc = -100000;
            if (!rst && i2c_exec) begin
                rec_rw = i2c_rh_wl; rec_addr = i2c_addr; rec_dw = i2c_data_w;
                tr_rw.push_back(rec_rw); tr_addr.push_back(rec_addr); tr_dw.push_back(rec_dw);
                if (cyc - last_exec_cyc < GAP) spacing_err++;
                last_exec_cyc = cyc;
                hold = 1'b0;
                if (!rec_rw) begin
                    rd_idx = 0;
                    resp = 8'h00;
                end else begin
                    resp = (rd_idx == 0) ? 8'($urandom) : samp_tab[rec_addr[1:0]][rd_idx-1];
                    hold = (rd_idx == 0) && (int'(rec_addr[1:0]) == withhold_ch);
                    rd_idx++;
                end
                if (hold) begin
                    wh_exec_cyc = cyc;
                end else begin
                    lat = $urandom_range(2, 6);
                    aborted = 1'b0;
                    for (int k = 0; k < int'(lat); k++) begin
                        @(posedge clk);
                        #1;
                        if (rst) aborted = 1'b1;
                        if (!aborted) begin
                            if (i2c_exec) proto_err++;
                            if ({i2c_rh_wl, i2c_addr, i2c_data_w} !== {rec_rw, rec_addr, rec_dw}) stab_err++;
                        end
                    end
                    if (!aborted) begin
                        i2c_data_r = resp;
                        i2c_done = 1'b1;
                        @(posedge clk);
                        #1;
                        i2c_done = 1'b0;
                        i2c_data_r = 8'($urandom);
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (ch_valid[i]) begin vld_cnt[i]++; vld_cyc = cyc; end
        if (scan_done) sd_cnt++;
        if (timeout_err && !to_prev) to_rise_cyc = cyc;
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        to_prev = timeout_err;
        busy_prev = busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [7:0] ref_val(input int c);
        int s;
        s = 0;
        for (int k = 0; k < NKEEP; k++) s += samp_tab[c][k];
        return 8'(s / NKEEP);
    endfunction

    task automatic clear_logs();
        tr_rw.delete(); tr_addr.delete(); tr_dw.delete();
        proto_err = 0; stab_err = 0; spacing_err = 0; sd_cnt = 0;
        vld_cyc = -1; busy_fall_cyc = -1; to_rise_cyc = -1;
        for (int i = 0; i < 4; i++) vld_cnt[i] = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; scan_en = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) exp_data[i] = 8'h00;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; scan_en = 1'b0; ch_mask = 4'h0; dac_val = 8'h00;
        for (int i = 0; i < 4; i++) exp_data[i] = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w} !== 26'd0) begin
            errors++; $display("FAIL reset_bus: got %b %b %h %h required all 0", i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w);
        end
        checks++;
        if ({ch_data, ch_valid, scan_done, busy, timeout_err} !== 39'd0) begin
            errors++; $display("FAIL reset_status: got data=%h vld=%b sd=%b busy=%b to=%b required all 0", ch_data, ch_valid, scan_done, busy, timeout_err);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_without_scan_en: busy=%b required 0", busy); end
    endtask

    // One pass over mask (channel wh gets its dummy read withheld), checked against the transaction/register model.
    task automatic test_scan(input string name, input logic [3:0] mask, input logic [7:0] dac, input int wh);
        int last_wr, tmo;
        bit wh_hit;
        logic [31:0] exp_word;
        exp_rw.delete(); exp_addr.delete(); exp_dw.delete();
        last_wr = 0;
        wh_hit = 1'b0;
        for (int c = 0; c < 4; c++) if (mask[c]) begin
            last_wr = exp_rw.size();
            if (c == wh) wh_hit = 1'b1;
            for (int r = 0; r < ((c == wh) ? 2 : TPC); r++) begin
                exp_rw.push_back(r != 0); exp_addr.push_back(16'h0040 | 16'(c)); exp_dw.push_back(dac);
            end
        end
        clear_logs();
        withhold_ch = wh;
        @(negedge clk);
        ch_mask = mask; dac_val = dac; scan_en = 1'b1;
        tmo = 0;
        for (int k = 0; k < 5000 && tr_rw.size() < last_wr + 1; k++) @(negedge clk);
        if (tr_rw.size() < last_wr + 1) tmo = 1;
        // Last channel has started: stop after this pass; also scramble inputs to show they are ignored mid-pass.
        scan_en = 1'b0; ch_mask = 4'($urandom); dac_val = 8'($urandom);
        for (int k = 0; k < 5000 && busy; k++) @(negedge clk);
        if (busy) tmo = 1;
        repeat (3) @(negedge clk);
        withhold_ch = -1;
        for (int c = 0; c < 4; c++) if (mask[c] && c != wh) exp_data[c] = ref_val(c);
        exp_word = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};

        checks++;
        if (tmo != 0) begin errors++; $display("FAIL %s_wait: pass did not complete within cycle budget", name); end
        checks++;
        if (tr_rw.size() != exp_rw.size()) begin
            errors++; $display("FAIL %s_txn_count: got %0d required %0d", name, tr_rw.size(), exp_rw.size());
        end else begin
            for (int i = 0; i < exp_rw.size(); i++) begin
                checks++;
                if ({tr_rw[i], tr_addr[i], tr_dw[i]} !== {exp_rw[i], exp_addr[i], exp_dw[i]}) begin
                    errors++;
                    $display("FAIL %s_txn%0d: got rw=%b addr=%h dw=%h required rw=%b addr=%h dw=%h",
                             name, i, tr_rw[i], tr_addr[i], tr_dw[i], exp_rw[i], exp_addr[i], exp_dw[i]);
                    break;
                end
            end
        end
        checks++;
        if (ch_data !== exp_word) begin errors++; $display("FAIL %s_ch_data: got %h required %h", name, ch_data, exp_word); end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (vld_cnt[c] != ((mask[c] && c != wh) ? 1 : 0)) begin
                errors++; $display("FAIL %s_ch_valid%0d: got %0d pulses required %0d", name, c, vld_cnt[c], (mask[c] && c != wh) ? 1 : 0);
            end
        end
        checks++;
        if (sd_cnt != 1) begin errors++; $display("FAIL %s_scan_done: got %0d pulses required 1", name, sd_cnt); end
        checks++;
        if (timeout_err !== wh_hit) begin errors++; $display("FAIL %s_timeout_err: got %b required %b", name, timeout_err, wh_hit); end
        checks++;
        if (proto_err + stab_err + spacing_err != 0) begin
            errors++; $display("FAIL %s_protocol: exec_outstanding=%0d unstable=%0d spacing=%0d required all 0", name, proto_err, stab_err, spacing_err);
        end
    endtask

    task automatic test_full_scan();
        for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) samp_tab[c][k] = 8'(8'h11 * (c + 1));
`ifdef PCF8591_AVG_EN
        samp_tab[0][0] = 8'd10; samp_tab[0][1] = 8'd20; samp_tab[0][2] = 8'd30; samp_tab[0][3] = 8'd41;
`endif
        test_scan("full", 4'b1111, 8'h80, -1);
        checks++;
`ifdef PCF8591_AVG_EN
        if (ch_data !== 32'h44332219) begin errors++; $display("FAIL full_const: got %h required 44332219", ch_data); end
`else
        if (ch_data !== 32'h44332211) begin errors++; $display("FAIL full_const: got %h required 44332211", ch_data); end
`endif
    endtask

    task automatic test_partial_mask();
        apply_reset();
        for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) samp_tab[c][k] = 8'($urandom);
        test_scan("mask1010", 4'b1010, 8'($urandom), -1);
        checks++;
        if (ch_data[7:0] !== 8'h00) begin errors++; $display("FAIL mask1010_ch0_untouched: got %h required 00", ch_data[7:0]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) samp_tab[c][k] = 8'($urandom);
            test_scan("random", 4'($urandom_range(1, 15)), 8'($urandom), -1);
        end
        test_scan("single", 4'b0100, 8'($urandom), -1);
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) samp_tab[c][k] = 8'($urandom);
        test_scan("timeout", 4'b1111, 8'($urandom), 2);
        checks++;
        if (to_rise_cyc - wh_exec_cyc != TO) begin
            errors++; $display("FAIL timeout_delay: got %0d cycles required %0d", to_rise_cyc - wh_exec_cyc, TO);
        end
    endtask

    task automatic test_scan_en_drop();
        int tmo;
        apply_reset();
        for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) samp_tab[c][k] = 8'($urandom);
        clear_logs();
        @(negedge clk);
        ch_mask = 4'b1111; dac_val = 8'($urandom); scan_en = 1'b1;
        tmo = 0;
        for (int k = 0; k < 2000 && tr_rw.size() < 1; k++) @(negedge clk);
        @(negedge clk);
        scan_en = 1'b0;
        for (int k = 0; k < 2000 && busy; k++) @(negedge clk);
        if (busy || tr_rw.size() < 1) tmo = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (tmo != 0) begin errors++; $display("FAIL drop_wait: channel did not finish within budget"); end
        checks++;
        if (tr_rw.size() != TPC || tr_addr[tr_rw.size()-1] !== 16'h0040) begin
            errors++; $display("FAIL drop_txns: got %0d transactions required %0d all at 0040", tr_rw.size(), TPC);
        end
        checks++;
        if ({vld_cnt[3], vld_cnt[2], vld_cnt[1], vld_cnt[0]} != {32'd0, 32'd0, 32'd0, 32'd1}) begin
            errors++; $display("FAIL drop_ch_valid: got %0d%0d%0d%0d required 0001", vld_cnt[3], vld_cnt[2], vld_cnt[1], vld_cnt[0]);
        end
        checks++;
        if (ch_data !== {24'h0, ref_val(0)}) begin errors++; $display("FAIL drop_ch_data: got %h required %h", ch_data, {24'h0, ref_val(0)}); end
        checks++;
        if (sd_cnt != 0) begin errors++; $display("FAIL drop_scan_done: got %0d pulses required 0", sd_cnt); end
        checks++;
        if (busy_fall_cyc != vld_cyc) begin errors++; $display("FAIL drop_busy_fall: got cycle %0d required %0d", busy_fall_cyc, vld_cyc); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] m;
        apply_reset();
        clear_logs();
        m = 4'($urandom_range(1, 15));
        @(negedge clk);
        ch_mask = m; dac_val = 8'($urandom); scan_en = 1'b1;
        for (int k = 0; k < 2000 && tr_rw.size() < 3; k++) @(negedge clk);
        checks++;
        if (tr_rw.size() < 3) begin errors++; $display("FAIL rstmid_reach_rd1: got %0d transactions required 3", tr_rw.size()); end
        @(negedge clk);
        checks++;
        if (i2c_rh_wl !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_in_rd1_wait: rh_wl=%b busy=%b required 1 1", i2c_rh_wl, busy); end
        rst = 1'b1;
        #1;
        checks++;
        if ({i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, ch_data, ch_valid, scan_done, busy, timeout_err} !== 65'd0) begin
            errors++; $display("FAIL rstmid_outputs: got rh_wl=%b addr=%h dw=%h data=%h busy=%b required all 0", i2c_rh_wl, i2c_addr, i2c_data_w, ch_data, busy);
        end
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (i2c_exec !== 1'b0) begin errors++; $display("FAIL rstmid_exec_before_edge: got %b required 0", i2c_exec); end
        @(posedge clk);
        #2;
        checks++;
        if ({i2c_exec, i2c_rh_wl, i2c_addr} !== {2'b10, 16'h0040 | 16'(pcf8591_pkg::first_ch(m))}) begin
            errors++; $display("FAIL rstmid_restart: got exec=%b rh_wl=%b addr=%h required 1 0 %h", i2c_exec, i2c_rh_wl, i2c_addr, 16'h0040 | 16'(pcf8591_pkg::first_ch(m)));
        end
        @(negedge clk);
        scan_en = 1'b0;
        for (int k = 0; k < 2000 && busy; k++) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_partial_mask();
        test_random();
        test_timeout();
        test_scan_en_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
